// File: rtl/ieee_alu_pkg.sv
// Shared definitions for the single-precision ALU datapath: widths, the
// normalizer state encoding and the result-flag field order.
package ieee_alu_pkg;
  localparam int MANT_W   = 24;
  localparam int EXP_W    = 8;
  localparam int EXP_MAX  = 255;
  localparam int EXP_BIAS = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic unf;
  } flags_t;
endpackage

// File: rtl/fp_mantissa_normalizer.sv
// Post-add mantissa normalizer: carry fix-up in one edge, leading-zero
// removal one bit per clock, valid/ready on both sides.
module fp_mantissa_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_cout,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);
  import ieee_alu_pkg::*;

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EONE = EXP_W'(1);

  state_t            state, state_nx;
  logic              armed;
  logic [MANT_W-1:0] mant, mant_nx, sh_mant;
  logic [EXP_W-1:0]  exp_r, exp_nx, sh_exp, e;
  logic [EXP_W:0]    e_inc;
  logic              sign, sign_nx;
  flags_t            flags, flags_nx;

  // Denormal inputs carry an effective exponent of 1.
  assign e       = (in_exp == '0) ? EONE : in_exp;
  assign e_inc   = {1'b0, e} + 1'b1;
  assign sh_mant = mant << 1;
  assign sh_exp  = exp_r - 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    mant_nx  = mant;
    exp_nx   = exp_r;
    sign_nx  = sign;
    flags_nx = flags;
    case (state)
      IDLE: if (in_valid && armed) begin
        sign_nx  = in_sign;
        flags_nx = '0;
        state_nx = DONE;
        if (in_cout) begin
          if (e_inc >= {1'b0, EMAX}) begin
            mant_nx      = '0;
            exp_nx       = EMAX;
            flags_nx.ovf = 1'b1;
          end else begin
            mant_nx = {1'b1, in_mant[MANT_W-1:1]};
            exp_nx  = e_inc[EXP_W-1:0];
          end
        end else if (in_mant == '0) begin
          mant_nx       = '0;
          exp_nx        = '0;
          flags_nx.zero = 1'b1;
        end else if (in_mant[MANT_W-1]) begin
          mant_nx = in_mant;
          exp_nx  = e;
        end else if (e == EONE) begin
          mant_nx      = in_mant;
          exp_nx       = '0;
          flags_nx.unf = 1'b1;
        end else begin
          mant_nx  = in_mant;
          exp_nx   = e;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        mant_nx = sh_mant;
        exp_nx  = sh_exp;
        if (sh_mant[MANT_W-1]) begin
          state_nx = DONE;
        end else if (sh_exp == EONE) begin
          exp_nx       = '0;
          flags_nx.unf = 1'b1;
          state_nx     = DONE;
        end
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mant  <= '0;
      exp_r <= '0;
      sign  <= 1'b0;
      flags <= '0;
    end else begin
      mant  <= mant_nx;
      exp_r <= exp_nx;
      sign  <= sign_nx;
      flags <= flags_nx;
    end
  end

  assign in_ready  = (state == IDLE) && armed;
  assign out_valid = (state == DONE);
  assign out_mant  = mant;
  assign out_exp   = exp_r;
  assign out_sign  = sign;
  assign out_zero  = flags.zero;
  assign out_ovf   = flags.ovf;
  assign out_unf   = flags.unf;
endmodule

// File: tb/tb_fp_mantissa_normalizer.sv
// Directed bench for fp_mantissa_normalizer with hand-computed results.
module tb_fp_mantissa_normalizer;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_cout, in_sign;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid, out_ready, out_sign, out_zero, out_ovf, out_unf;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;

  int checks = 0;
  int failures = 0;

  fp_mantissa_normalizer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant),
    .in_cout(in_cout), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_exp(out_exp), .out_sign(out_sign), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [35:0] res_word();
    return {out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one operand, then wait (bounded) for out_valid; k = edges after E0.
  task automatic start_op(input string tag, input logic [23:0] m, input logic c,
                          input logic [7:0] e, input logic s);
    int w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
    in_mant = m; in_cout = c; in_exp = e; in_sign = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_mant = 24'($urandom); in_cout = 1'($urandom);
    in_exp = 8'($urandom); in_sign = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [23:0] m, input logic c,
                        input logic [7:0] e, input logic s,
                        input int k_exp, input logic [35:0] r_exp);
    int k = 0;
    bit busy_bad = 0;
    start_op(tag, m, c, e, s);
    while (!out_valid && k < 40) begin
      if (in_ready) busy_bad = 1;
      tick(); k++;
    end
    if (in_ready) busy_bad = 1;
    chk({tag, "_lat"}, 64'(k), 64'(k_exp));
    chk({tag, "_res"}, 64'(res_word()), 64'(r_exp));
    chk({tag, "_busy"}, 64'(busy_bad), 0);
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [35:0] snap;
    bit bad;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mant = '0; in_cout = 1'b0; in_exp = '0; in_sign = 1'b0;
    repeat (3) tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_res", res_word(), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_release", in_ready, 0);
    tick();
    chk("ready_after_rst", in_ready, 1);

    // {mant, exp, sign, zero, ovf, unf}
    run_op("normal", 24'h800000, 1'b0, 8'h80, 1'b1, 0, {24'h800000, 8'h80, 1'b1, 3'b000});
    pop("normal");
    run_op("max_shift", 24'h000001, 1'b0, 8'h80, 1'b0, 23, {24'h800000, 8'h69, 1'b0, 3'b000});
    pop("max_shift");
    run_op("carry", 24'h800000, 1'b1, 8'h7F, 1'b0, 0, {24'hC00000, 8'h80, 1'b0, 3'b000});
    pop("carry");
    run_op("carry_ovf", 24'h123456, 1'b1, 8'hFE, 1'b1, 0, {24'h000000, 8'hFF, 1'b1, 3'b010});
    pop("carry_ovf");
    run_op("unf_shift", 24'h000100, 1'b0, 8'h03, 1'b0, 2, {24'h000400, 8'h00, 1'b0, 3'b001});
    pop("unf_shift");
    run_op("denorm_in", 24'h400000, 1'b0, 8'h00, 1'b1, 0, {24'h400000, 8'h00, 1'b1, 3'b001});
    pop("denorm_in");
    run_op("one_step", 24'h400000, 1'b0, 8'h02, 1'b0, 1, {24'h800000, 8'h01, 1'b0, 3'b000});
    pop("one_step");
    run_op("carry_e0", 24'h800000, 1'b1, 8'h00, 1'b0, 0, {24'hC00000, 8'h02, 1'b0, 3'b000});
    pop("carry_e0");

    // Zero result, then backpressure with ignored input pulses.
    run_op("zero", 24'h000000, 1'b0, 8'h55, 1'b1, 0, {24'h000000, 8'h00, 1'b1, 3'b100});
    snap = res_word();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_mant = 24'h800000 >> i; in_exp = 8'(8'h20 + i); in_cout = i[0];
      tick();
      if (res_word() !== snap || !out_valid || in_ready) bad = 1;
    end
    in_valid = 1'b0;
    chk("bp_hold", bad, 0);
    pop("zero");

    // Reset in the middle of a long shift.
    start_op("rst_mid", 24'h000001, 1'b0, 8'h80, 1'b0);
    repeat (9) tick();
    chk("rst_mid_busy", {out_valid, in_ready}, 2'b00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_res", res_word(), 0);
    chk("rst_mid_ready", in_ready, 0);
    tick();
    chk("rst_mid_release", in_ready, 1);
    run_op("after_rst", 24'h400000, 1'b0, 8'h10, 1'b0, 1, {24'h800000, 8'h0F, 1'b0, 3'b000});
    pop("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
